// File: rtl/ram_stream_loader.sv
// ram_stream_loader: write-side front end for the data RAM. It fills a contiguous,
// wrapping address region from a valid/ready word stream. Outside a load, the RAM
// write port is a pass-through from the CPU.
// Optional macro RAM_STREAM_LOADER_CHECKSUM_EN adds a modulo-2^DATA_W sum of the
// accepted words.
module ram_stream_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done,
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] IdxOne = {{ADDR_W{1'b0}}, 1'b1};

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_count;
    // The word index doubles as the words-written count; both clear on start and
    // step on every accepted word.
    logic [ADDR_W:0]     r_index;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_last;
    logic [ADDR_W-1:0]   w_stream_addr;

    assign w_start_ok    = (r_state == StIdle) && start;
    assign w_accept      = (r_state == StLoad) && s_valid;
    assign w_last        = w_accept && (r_index == (r_count - IdxOne));
    // The truncation to ADDR_W bits gives the modulo-2^ADDR_W region wrap.
    assign w_stream_addr = r_base + r_index[ADDR_W-1:0];

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A start seen outside IDLE is dropped, not queued.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = (count == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Load parameters and the word index: captured on start, stepped on each accept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_base  <= '0;
            r_count <= '0;
            r_index <= '0;
        end else if (w_start_ok) begin
            r_base  <= base_addr;
            r_count <= count;
            r_index <= '0;
        end else if (w_accept) begin
            r_index <= r_index + IdxOne;
        end
    end

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of the words accepted in the current load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + s_data;
        end
    end

    assign checksum = r_checksum;
`endif

    // RAM port mux. The stream owns the port during LOAD and CPU writes are
    // dropped; otherwise the CPU drives the port, including while reset is held.
    always_comb begin
        ram_in      = cpu_in;
        ram_load    = cpu_load;
        ram_address = cpu_address;
        s_ready     = 1'b0;
        if (r_state == StLoad) begin
            ram_in      = s_data;
            ram_load    = s_valid;
            ram_address = w_stream_addr;
            s_ready     = 1'b1;
        end
    end

    assign busy          = (r_state == StLoad);
    assign done          = (r_state == StDone);
    assign words_written = r_index;

endmodule
